clock_time_ctrl: RTL and testbench

- Control stage directly upstream of the seconds, minutes and hours progcnt instances in the digital clock.
- Divides the system clock into a timebase tick and debounces the mode and increment buttons.
- Runs a RUN/SET_HR/SET_MIN state machine that produces the counters' one-cycle enable pulses, including carry chaining from the counters' fed-back count values.

---
 rtl/clock_time_ctrl_if.sv | 25 ++
 rtl/clock_time_ctrl.sv | 178 +++++++++++++++++
 tb/tb_clock_time_ctrl.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/clock_time_ctrl_if.sv
// rtl/clock_time_ctrl_if.sv - button, counter feedback and enable/status signals of clock_time_ctrl
// master: the control block; slave: the buttons and progcnt counters around it.
interface clock_time_ctrl_if;
    logic       btn_mode;
    logic       btn_inc;
    logic [5:0] sec_cnt;
    logic [5:0] min_cnt;
    logic [4:0] hr_cnt;
    logic       sec_en;
    logic       min_en;
    logic       hr_en;
    logic       sec_clr;
    logic [1:0] mode;
    logic       blink;

    modport master (
        input  btn_mode, btn_inc, sec_cnt, min_cnt, hr_cnt,
        output sec_en, min_en, hr_en, sec_clr, mode, blink
    );

    modport slave (
        output btn_mode, btn_inc, sec_cnt, min_cnt, hr_cnt,
        input  sec_en, min_en, hr_en, sec_clr, mode, blink
    );
endinterface

// File: rtl/clock_time_ctrl.sv
// rtl/clock_time_ctrl.sv - timebase, button debounce and RUN/SET_HR/SET_MIN enable generation
// Optional inc auto-repeat in the SET states: CLOCK_CTRL_AUTOREPEAT_EN.
module clock_time_ctrl #(
    parameter int unsigned CLK_HZ     = 100000000,
    parameter int unsigned TICK_HZ    = 1,
    parameter int unsigned DEB_CYCLES = 1000000,
    parameter int unsigned SEC_MAX    = 59,
    parameter int unsigned MIN_MAX    = 59,
    parameter int unsigned HR_MAX     = 23
) (
    input  logic                clk,
    input  logic                rst,
    clock_time_ctrl_if.master   bus
);
    localparam int unsigned PRE_TC = CLK_HZ / TICK_HZ - 1;
    localparam int unsigned PRE_W  = (PRE_TC > 0) ? $clog2(PRE_TC + 1) : 1;
    localparam int unsigned DEB_W  = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [PRE_W-1:0] PRE_TC_V = PRE_W'(PRE_TC);
    localparam logic [DEB_W-1:0] DEB_TC_V = DEB_W'(DEB_CYCLES - 1);
    localparam logic [5:0]       SEC_TC   = 6'(SEC_MAX);
    localparam logic [5:0]       MIN_TC   = 6'(MIN_MAX);
    localparam logic [4:0]       HR_TC    = 5'(HR_MAX);

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        SET_HR  = 2'd1,
        SET_MIN = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [PRE_W-1:0]   pre_q, pre_d;
    logic               tick_q, tick_d;
    logic               sec_en_q, sec_en_d;
    logic               min_en_q, min_en_d;
    logic               hr_en_q, hr_en_d;
    logic               sec_clr_q, sec_clr_d;
    logic               blink_q, blink_d;

    // Bit 0 = mode button, bit 1 = inc button.
    logic [1:0]         sync1_q, sync2_q, lvl_q, press_q;
    logic [DEB_W-1:0]   deb_q [2];

    logic               mode_press, inc_press, inc_lvl, rep_fire;
    logic               sec_hit, min_hit;

    assign mode_press = press_q[0];
    assign inc_press  = press_q[1];
    assign inc_lvl    = lvl_q[1];
    assign sec_hit    = (bus.sec_cnt == SEC_TC);
    assign min_hit    = (bus.min_cnt == MIN_TC);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
            lvl_q   <= '0;
            press_q <= '0;
            for (int b = 0; b < 2; b++) deb_q[b] <= '0;
        end else begin
            sync1_q <= {bus.btn_inc, bus.btn_mode};
            sync2_q <= sync1_q;
            for (int b = 0; b < 2; b++) begin
                press_q[b] <= 1'b0;
                if (sync2_q[b] == lvl_q[b]) begin
                    deb_q[b] <= '0;
                end else if (deb_q[b] == DEB_TC_V) begin
                    deb_q[b]   <= '0;
                    lvl_q[b]   <= sync2_q[b];
                    press_q[b] <= sync2_q[b];
                end else begin
                    deb_q[b] <= deb_q[b] + DEB_W'(1);
                end
            end
        end
    end

`ifdef CLOCK_CTRL_AUTOREPEAT_EN
    // Counts ticks of continuous hold since the press; from the third tick on each tick repeats.
    logic [1:0] rep_q, rep_d;

    always_comb begin
        rep_d    = rep_q;
        rep_fire = 1'b0;
        if (state_q == RUN || mode_press || !inc_lvl || inc_press) begin
            rep_d = '0;
        end else if (tick_q) begin
            if (rep_q == 2'd2) rep_fire = 1'b1;
            else               rep_d    = rep_q + 2'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) rep_q <= '0;
        else     rep_q <= rep_d;
    end
`else
    assign rep_fire = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        sec_en_d  = 1'b0;
        min_en_d  = 1'b0;
        hr_en_d   = 1'b0;
        sec_clr_d = 1'b0;
        blink_d   = blink_q;
        case (state_q)
            RUN: begin
                sec_en_d = tick_q;
                min_en_d = tick_q && sec_hit;
                hr_en_d  = tick_q && sec_hit && min_hit;
                blink_d  = 1'b1;
                if (mode_press) state_d = SET_HR;
            end
            SET_HR: begin
                if (tick_q) blink_d = ~blink_q;
                if (mode_press) begin
                    state_d = SET_MIN;
                    blink_d = 1'b1;
                end else if (inc_press || rep_fire) begin
                    hr_en_d = 1'b1;
                end
            end
            SET_MIN: begin
                if (tick_q) blink_d = ~blink_q;
                if (mode_press) begin
                    state_d   = RUN;
                    blink_d   = 1'b1;
                    sec_clr_d = 1'b1;
                end else if (inc_press || rep_fire) begin
                    min_en_d = 1'b1;
                end
            end
            default: begin
                state_d = RUN;
                blink_d = 1'b1;
            end
        endcase

        // Restarting the prescaler with sec_clr gives a full period before the first RUN tick.
        if (sec_clr_d)              pre_d = '0;
        else if (pre_q == PRE_TC_V) pre_d = '0;
        else                        pre_d = pre_q + PRE_W'(1);
        tick_d = (pre_q == PRE_TC_V) && !sec_clr_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= RUN;
            pre_q     <= '0;
            tick_q    <= 1'b0;
            sec_en_q  <= 1'b0;
            min_en_q  <= 1'b0;
            hr_en_q   <= 1'b0;
            sec_clr_q <= 1'b0;
            blink_q   <= 1'b1;
        end else begin
            state_q   <= state_d;
            pre_q     <= pre_d;
            tick_q    <= tick_d;
            sec_en_q  <= sec_en_d;
            min_en_q  <= min_en_d;
            hr_en_q   <= hr_en_d;
            sec_clr_q <= sec_clr_d;
            blink_q   <= blink_d;
        end
    end

    assign bus.sec_en  = sec_en_q;
    assign bus.min_en  = min_en_q;
    assign bus.hr_en   = hr_en_q;
    assign bus.sec_clr = sec_clr_q;
    assign bus.mode    = state_q;
    assign bus.blink   = blink_q;

    hr_in_range: assert property (@(posedge clk) disable iff (rst) bus.hr_cnt <= HR_TC);

endmodule

// File: tb/tb_clock_time_ctrl.sv
// tb/tb_clock_time_ctrl.sv - directed bench for clock_time_ctrl with a model of the three counters
module tb_clock_time_ctrl;
    logic clk = 1'b0;
    logic rst;
    logic btn_mode, btn_inc;
    logic ld;
    logic [5:0] ld_s, ld_m, sec, mn;
    logic [4:0] ld_h, hr;

    int total = 0;
    int bad   = 0;
    int n_sec = 0, n_min = 0, n_hr = 0, n_b0 = 0, mode_chg = 0;
    logic [1:0] prev_mode = 2'd0;

    always #5 clk = ~clk;

    clock_time_ctrl_if bus();

    assign bus.btn_mode = btn_mode;
    assign bus.btn_inc  = btn_inc;
    assign bus.sec_cnt  = sec;
    assign bus.min_cnt  = mn;
    assign bus.hr_cnt   = hr;

    clock_time_ctrl #(
        .CLK_HZ(10), .TICK_HZ(1), .DEB_CYCLES(4),
        .SEC_MAX(59), .MIN_MAX(59), .HR_MAX(23)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always @(posedge clk) begin
        if (ld) begin
            sec <= ld_s;
            mn  <= ld_m;
            hr  <= ld_h;
        end else begin
            if (bus.sec_clr)     sec <= 6'd0;
            else if (bus.sec_en) sec <= (sec == 6'd59) ? 6'd0 : sec + 6'd1;
            if (bus.min_en)      mn  <= (mn == 6'd59) ? 6'd0 : mn + 6'd1;
            if (bus.hr_en)       hr  <= (hr == 5'd23) ? 5'd0 : hr + 5'd1;
        end
    end

    always @(negedge clk) begin
        n_sec = n_sec + int'(bus.sec_en);
        n_min = n_min + int'(bus.min_en);
        n_hr  = n_hr + int'(bus.hr_en);
        if (bus.mode != 2'd0 && !bus.blink) n_b0 = n_b0 + 1;
        if (bus.mode != prev_mode) mode_chg = mode_chg + 1;
        prev_mode = bus.mode;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total = total + 1;
        if (got !== exp) begin
            bad = bad + 1;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic set_time(input logic [4:0] h, input logic [5:0] m, input logic [5:0] s);
        @(negedge clk);
        ld = 1'b1; ld_h = h; ld_m = m; ld_s = s;
        @(negedge clk);
        ld = 1'b0;
    endtask

    task automatic press(input logic m, input logic i);
        @(negedge clk);
        btn_mode = m;
        btn_inc  = i;
        repeat (12) @(negedge clk);
        btn_mode = 1'b0;
        btn_inc  = 1'b0;
        repeat (12) @(negedge clk);
    endtask

    task automatic wait_sec_en(output logic found);
        found = 1'b0;
        for (int k = 0; k < 15 && !found; k++) begin
            @(negedge clk);
            if (bus.sec_en) found = 1'b1;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int first, second, mins, gap, extra, s0, h0, m0, b0, d;
        logic found;

        rst = 1'b1; btn_mode = 1'b0; btn_inc = 1'b0;
        ld = 1'b1; ld_s = 6'd0; ld_m = 6'd0; ld_h = 5'd0;
        repeat (3) @(negedge clk);
        chk("rst_mode", bus.mode, 0);
        chk("rst_blink", bus.blink, 1);
        chk("rst_outs", {bus.sec_en, bus.min_en, bus.hr_en, bus.sec_clr}, 0);
        ld  = 1'b0;
        rst = 1'b0;

        first = 0; second = 0; mins = 0;
        for (int k = 1; k <= 25; k++) begin
            @(negedge clk);
            if (bus.sec_en) begin
                if (first == 0) first = k;
                else if (second == 0) second = k;
            end
            if (bus.min_en) mins = mins + 1;
        end
        chk("first_sec_en", first, 11);
        chk("second_sec_en", second, 21);
        chk("no_min_en", mins, 0);

        set_time(5'd23, 6'd59, 6'd59);
        wait_sec_en(found);
        chk("wrap_seen", found, 1);
        chk("wrap_min_en", bus.min_en, 1);
        chk("wrap_hr_en", bus.hr_en, 1);
        @(negedge clk);
        chk("wrap_time", {hr, mn, sec}, 0);

        set_time(5'd5, 6'd10, 6'd59);
        wait_sec_en(found);
        chk("mcarry_seen", found, 1);
        chk("mcarry_min_en", bus.min_en, 1);
        chk("mcarry_hr_en", bus.hr_en, 0);
        @(negedge clk);
        chk("mcarry_time", {hr, mn, sec}, {5'd5, 6'd11, 6'd0});

        @(negedge clk);
        btn_mode = 1'b1;
        repeat (3) @(negedge clk);
        btn_mode = 1'b0;
        repeat (15) @(negedge clk);
        chk("glitch_mode", bus.mode, 0);

        m0 = mode_chg;
        btn_mode = 1'b1;
        repeat (100) @(negedge clk);
        chk("hold_mode", bus.mode, 1);
        btn_mode = 1'b0;
        repeat (12) @(negedge clk);
        chk("hold_once", mode_chg - m0, 1);

        set_time(5'd22, 6'd30, 6'd15);
        s0 = n_sec + n_min; h0 = n_hr; b0 = n_b0;
        press(1'b0, 1'b1);
        press(1'b0, 1'b1);
        press(1'b0, 1'b1);
        chk("sethr_pulses", n_hr - h0, 3);
        chk("sethr_hours", hr, 1);
        chk("sethr_frozen_en", n_sec + n_min - s0, 0);
        chk("sethr_frozen_time", {mn, sec}, {6'd30, 6'd15});
        chk("sethr_blinked", n_b0 > b0, 1);

        press(1'b1, 1'b0);
        chk("setmin_mode", bus.mode, 2);
        set_time(5'd1, 6'd59, 6'd15);
        m0 = n_min; h0 = n_hr;
        press(1'b0, 1'b1);
        chk("setmin_pulse", n_min - m0, 1);
        chk("setmin_minutes", mn, 0);
        chk("setmin_no_hr", n_hr - h0, 0);
        chk("setmin_hours", hr, 1);

        @(negedge clk);
        btn_mode = 1'b1;
        found = 1'b0;
        for (int k = 0; k < 30 && !found; k++) begin
            @(negedge clk);
            if (bus.sec_clr) found = 1'b1;
        end
        chk("exit_clr_seen", found, 1);
        chk("exit_mode", bus.mode, 0);
        chk("exit_blink", bus.blink, 1);
        gap = 0; extra = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (k == 1) chk("exit_sec_cleared", sec, 0);
            if (k == 8) btn_mode = 1'b0;
            if (bus.sec_clr) extra = extra + 1;
            if (bus.sec_en && gap == 0) gap = k;
        end
        chk("exit_clr_once", extra, 0);
        chk("exit_first_sec_en", gap, 11);
        repeat (12) @(negedge clk);

        press(1'b1, 1'b0);
        chk("simul_pre_mode", bus.mode, 1);
        h0 = n_hr;
        press(1'b1, 1'b1);
        chk("simul_mode", bus.mode, 2);
        chk("simul_no_hr", n_hr - h0, 0);

        @(negedge clk);
        btn_inc = 1'b1;
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            @(negedge clk);
            if (bus.min_en) found = 1'b1;
        end
        chk("arst_pending_seen", found, 1);
        #1 rst = 1'b1;
        #1;
        chk("arst_mode", bus.mode, 0);
        chk("arst_blink", bus.blink, 1);
        chk("arst_outs", {bus.sec_en, bus.min_en, bus.hr_en, bus.sec_clr}, 0);
        @(negedge clk);
        btn_inc = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (12) @(negedge clk);

        press(1'b1, 1'b0);
        press(1'b1, 1'b0);
        chk("rep_mode", bus.mode, 2);
        m0 = n_min;
        @(negedge clk);
        btn_inc = 1'b1;
        repeat (50) @(negedge clk);
        btn_inc = 1'b0;
        repeat (12) @(negedge clk);
        d = n_min - m0;
`ifdef CLOCK_CTRL_AUTOREPEAT_EN
        chk("autorepeat_count", (d >= 3 && d <= 4), 1);
`else
        chk("single_inc_count", d, 1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
